// File: rtl/phase_pkg.sv
// Shared constants and types for the phase-shift delay sequencer.
package phase_pkg;

  localparam int PERIOD_TICKS = 1250;

  // Largest legal |delay| for a generator wrapping every 'period' ticks
  function automatic int delay_max(input int period);
    return period / 2 - 1;
  endfunction

  localparam int DELAY_MAX = delay_max(PERIOD_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RAMP
  } state_e;

endpackage

// File: rtl/phase_shift_ctrl_if.sv
// Request bus between delay requesters and the phase-shift sequencer.
interface phase_shift_ctrl_if #(
  parameter int NREQ    = 4,
  parameter int DELAY_W = 11
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DELAY_W-1:0] req_delay;
  logic [NREQ-1:0]         req_ready;
  logic                    req_err;

  modport master (
    output req_valid,
    output req_delay,
    input  req_ready,
    input  req_err
  );

  modport slave (
    input  req_valid,
    input  req_delay,
    output req_ready,
    output req_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // Scan starts one past the pointer so the last winner is checked last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && any_o) ptr_d = idx_o;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/phase_shift_ctrl.sv
// Arbitrates delay-change requests and ramps the generator delay at period boundaries.
// Optional PHASE_SHIFT_CTRL_RAMP_EN: bounded per-period steps; otherwise the target is applied in one tick.
module phase_shift_ctrl
  import phase_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int PERIOD   = PERIOD_TICKS,
  parameter int DELAY_W  = 11,
  parameter int MAX_STEP = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  phase_shift_ctrl_if.slave         req,
  output logic signed [DELAY_W-1:0] delay_out,
  output logic                      period_tick,
  output logic                      busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic signed [DELAY_W:0] LIM = (DELAY_W+1)'(delay_max(PERIOD));

  state_e                    state_q, state_d;
  logic [CW-1:0]             pcnt_q, pcnt_d;
  logic signed [DELAY_W-1:0] delay_q, delay_d;
  logic signed [DELAY_W-1:0] target_q, target_d;
  logic signed [DELAY_W-1:0] val_q, val_d;
  logic [NREQ-1:0]           gnt_q, gnt_d;
  logic [NREQ-1:0]           ready_q, ready_d;
  logic                      err_q, err_d;

  logic                      tick;
  logic [NREQ-1:0]           arb_req, arb_gnt;
  logic [IW-1:0]             arb_idx;
  logic                      arb_any, arb_en;
  logic signed [DELAY_W-1:0] arb_val;
  logic signed [DELAY_W:0]   val_x;
  logic                      legal;
  logic signed [DELAY_W-1:0] ramp_nxt;

  // Period counter
  assign tick   = (pcnt_q == CW'(PERIOD - 1));
  assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

  // A requester still sees its ready pulse this cycle; keep it out of arbitration
  assign arb_req = req.req_valid & ~ready_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    arb_val = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_idx == IW'(i)) arb_val = req.req_delay[i*DELAY_W +: DELAY_W];
  end

  assign val_x = {val_q[DELAY_W-1], val_q};
  assign legal = (val_q != '0) && (val_x <= LIM) && (val_x >= -LIM);

`ifdef PHASE_SHIFT_CTRL_RAMP_EN
  localparam logic signed [DELAY_W:0] STEP = (DELAY_W+1)'(MAX_STEP);

  logic signed [DELAY_W:0] diff, mag, step, nxt;

  // Widened by one bit so target - delay cannot overflow
  always_comb begin
    diff = {target_q[DELAY_W-1], target_q} - {delay_q[DELAY_W-1], delay_q};
    mag  = (diff < 0) ? -diff : diff;
    step = (mag > STEP) ? STEP : mag;
    nxt  = {delay_q[DELAY_W-1], delay_q} + ((diff < 0) ? -step : step);
    // The generator cannot take zero delay: hop one unit past it
    if (nxt == '0) nxt = (diff < 0) ? '1 : (DELAY_W+1)'(1);
    ramp_nxt = DELAY_W'(nxt);
  end
`else
  logic ramp_unused;

  assign ramp_unused = (MAX_STEP != 0);
  assign ramp_nxt    = target_q;
`endif

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    target_d = target_q;
    val_d    = val_q;
    gnt_d    = gnt_q;
    ready_d  = '0;
    err_d    = 1'b0;
    arb_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_en  = 1'b1;
          val_d   = arb_val;
          gnt_d   = arb_gnt;
          state_d = CHECK;
        end
      end
      CHECK: begin
        ready_d = gnt_q;
        if (!legal) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          target_d = val_q;
          state_d  = (val_q == delay_q) ? IDLE : RAMP;
        end
      end
      RAMP: begin
        if (tick) begin
          delay_d = ramp_nxt;
          if (ramp_nxt == target_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      delay_q  <= DELAY_W'(1);
      target_q <= DELAY_W'(1);
      val_q    <= '0;
      gnt_q    <= '0;
      ready_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      delay_q  <= delay_d;
      target_q <= target_d;
      val_q    <= val_d;
      gnt_q    <= gnt_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign delay_out     = delay_q;
  assign period_tick   = tick;
  assign busy          = (state_q != IDLE);
  assign req.req_ready = ready_q;
  assign req.req_err   = err_q;

endmodule
